axi_lite_alu_sequencer: RTL

//  AXI-Lite master that runs one arithmetic operation on the AXI-Lite ALU register slave.
//  The slave map is: srcA @0x00, srcB @0x04, add @0x08, sub @0x0C, mult @0x10.

---
 rtl/axi_lite_alu_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_alu_sequencer.sv
// AXI-Lite master that runs one ALU operation on the ALU register slave:
// write srcA, write srcB, wait for the result to settle, then read the result register.
module axi_lite_alu_sequencer #(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    SETTLE_CYCLES = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [DATA_WIDTH-1:0]   req_a,
  input  logic [DATA_WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_awaddr,
  output logic                    M_AXI_LITE_awvalid,
  input  logic                    M_AXI_LITE_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_LITE_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_LITE_wstrb,
  output logic                    M_AXI_LITE_wvalid,
  input  logic                    M_AXI_LITE_wready,
  input  logic [1:0]              M_AXI_LITE_bresp,
  input  logic                    M_AXI_LITE_bvalid,
  output logic                    M_AXI_LITE_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_araddr,
  output logic                    M_AXI_LITE_arvalid,
  input  logic                    M_AXI_LITE_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_LITE_rdata,
  input  logic [1:0]              M_AXI_LITE_rresp,
  input  logic                    M_AXI_LITE_rvalid,
  output logic                    M_AXI_LITE_rready
);

  generate
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
      $error("axi_lite_alu_sequencer: DATA_WIDTH must be 32 or 64");
    end
    if (ADDR_WIDTH < 5) begin : g_bad_addr_width
      $error("axi_lite_alu_sequencer: ADDR_WIDTH must be >= 5");
    end
  endgenerate

  localparam logic [ADDR_WIDTH-1:0] OFF_A   = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_B   = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] OFF_ADD = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_SUB = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] OFF_MUL = ADDR_WIDTH'(8'h10);

  localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [3:0] {IDLE, WR_A, BR_A, WR_B, BR_B, SETTLE, RD, RR, RSP} state_t;

  state_t                  state;
  logic [1:0]              op_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic                    aw_done;
  logic                    w_done;
  logic [CNT_W-1:0]        settle_cnt;
  logic                    aw_fire;
  logic                    w_fire;

  assign aw_fire = M_AXI_LITE_awvalid && M_AXI_LITE_awready;
  assign w_fire  = M_AXI_LITE_wvalid  && M_AXI_LITE_wready;

  function automatic logic [ADDR_WIDTH-1:0] result_addr(input logic [1:0] op);
    case (op)
      2'd0:    result_addr = BASE_ADDR + OFF_ADD;
      2'd1:    result_addr = BASE_ADDR + OFF_SUB;
      default: result_addr = BASE_ADDR + OFF_MUL;
    endcase
  endfunction

  // NOTE: non-blocking assignments only in clocked logic, so every branch sees pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= IDLE;
      op_q               <= '0;
      b_q                <= '0;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      settle_cnt         <= '0;
      req_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
      rsp_err            <= 2'b00;
      busy               <= 1'b0;
      M_AXI_LITE_awaddr  <= '0;
      M_AXI_LITE_awvalid <= 1'b0;
      M_AXI_LITE_wdata   <= '0;
      M_AXI_LITE_wstrb   <= '0;
      M_AXI_LITE_wvalid  <= 1'b0;
      M_AXI_LITE_bready  <= 1'b0;
      M_AXI_LITE_araddr  <= '0;
      M_AXI_LITE_arvalid <= 1'b0;
      M_AXI_LITE_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            op_q      <= req_op;
            b_q       <= req_b;
            rsp_data  <= '0;
            rsp_err   <= 2'b00;
            if (req_op == 2'd3) begin
              rsp_err   <= 2'b10;
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else begin
              M_AXI_LITE_awaddr  <= BASE_ADDR + OFF_A;
              M_AXI_LITE_wdata   <= req_a;
              M_AXI_LITE_wstrb   <= '1;
              M_AXI_LITE_awvalid <= 1'b1;
              M_AXI_LITE_wvalid  <= 1'b1;
              aw_done            <= 1'b0;
              w_done             <= 1'b0;
              state              <= WR_A;
            end
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        // NOTE: valids are registered and only cleared by their own handshake, never gated by ready.
        WR_A, WR_B: begin
          if (aw_fire) begin
            M_AXI_LITE_awvalid <= 1'b0;
            aw_done            <= 1'b1;
          end
          if (w_fire) begin
            M_AXI_LITE_wvalid <= 1'b0;
            w_done            <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            M_AXI_LITE_bready <= 1'b1;
            state             <= (state == WR_A) ? BR_A : BR_B;
          end
        end
        BR_A: begin
          if (M_AXI_LITE_bvalid) begin
            M_AXI_LITE_bready  <= 1'b0;
            if (rsp_err == 2'b00) rsp_err <= M_AXI_LITE_bresp;
            M_AXI_LITE_awaddr  <= BASE_ADDR + OFF_B;
            M_AXI_LITE_wdata   <= b_q;
            M_AXI_LITE_awvalid <= 1'b1;
            M_AXI_LITE_wvalid  <= 1'b1;
            aw_done            <= 1'b0;
            w_done             <= 1'b0;
            state              <= WR_B;
          end
        end
        BR_B: begin
          if (M_AXI_LITE_bvalid) begin
            M_AXI_LITE_bready <= 1'b0;
            if (rsp_err == 2'b00) rsp_err <= M_AXI_LITE_bresp;
            if (SETTLE_CYCLES == 0) begin
              M_AXI_LITE_araddr  <= result_addr(op_q);
              M_AXI_LITE_arvalid <= 1'b1;
              state              <= RD;
            end else begin
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            M_AXI_LITE_araddr  <= result_addr(op_q);
            M_AXI_LITE_arvalid <= 1'b1;
            state              <= RD;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        RD: begin
          if (M_AXI_LITE_arready) begin
            M_AXI_LITE_arvalid <= 1'b0;
            M_AXI_LITE_rready  <= 1'b1;
            state              <= RR;
          end
        end
        RR: begin
          if (M_AXI_LITE_rvalid) begin
            M_AXI_LITE_rready <= 1'b0;
            rsp_data          <= M_AXI_LITE_rdata;
            if (rsp_err == 2'b00) rsp_err <= M_AXI_LITE_rresp;
            rsp_valid         <= 1'b1;
            state             <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
